// File: rtl/subneg_pkg.sv
// Shared types for the SUBNEG fetch slice: fetch FSM states and the issue bundle.
package subneg_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        REQ_B,
        REQ_C,
        ISSUE,
        WAIT_EXEC,
        HALT
    } fetch_state_t;

    // Issue bundle handed to the execute stage; fields are sized by DEFAULT_WIDTH.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic [DEFAULT_WIDTH-1:0] c;
        logic [DEFAULT_WIDTH-1:0] pc;
    } instr_t;

endpackage

// File: rtl/subneg_fetch_inc.sv
// inc: modulo-2^WIDTH incrementer that supplies the sequential next PC.
module inc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    assign out = in + WIDTH'(1);

endmodule

// File: rtl/subneg_fetch.sv
// SUBNEG instruction fetch sequencer: reads A/B/C words, issues them, then follows the
// execute result. Optional PC wrap detection is enabled with `define SUBNEG_PC_WRAP_CHECK_EN.
module subneg_fetch
    import subneg_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             exec_done,
    input  logic             branch_taken,
    output logic             halted,
`ifdef SUBNEG_PC_WRAP_CHECK_EN
    output logic             pc_ovf,
`endif
    output logic [WIDTH-1:0] pc
);

    // The issue bundle type is fixed-width, so the datapath must match it.
    if (WIDTH != DEFAULT_WIDTH) begin : g_width_check
        $error("subneg_fetch: WIDTH must equal DEFAULT_WIDTH");
    end

    fetch_state_t     state, state_nxt;
    logic [WIDTH-1:0] pc_inc, pc_nxt;
    instr_t           bundle, bundle_nxt;
    logic             word_fire;
    logic             wrap_fire;

    inc #(.WIDTH(WIDTH)) u_inc (
        .in  (pc),
        .out (pc_inc)
    );

    assign mem_req     = (state == REQ_A) || (state == REQ_B) || (state == REQ_C);
    assign mem_addr    = pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);
    assign op_a        = bundle.a;
    assign op_b        = bundle.b;
    assign op_c        = bundle.c;
    assign instr_pc    = bundle.pc;

    assign word_fire = mem_req && mem_ack;
    assign wrap_fire = word_fire && (&pc);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt  = state;
        pc_nxt     = pc;
        bundle_nxt = bundle;

        unique case (state)
            IDLE: begin
                if (start) state_nxt = REQ_A;
            end
            REQ_A: begin
                if (mem_ack) begin
                    bundle_nxt.a  = mem_rdata;
                    bundle_nxt.pc = pc;
                    pc_nxt        = pc_inc;
                    state_nxt     = REQ_B;
                end
            end
            REQ_B: begin
                if (mem_ack) begin
                    bundle_nxt.b = mem_rdata;
                    pc_nxt       = pc_inc;
                    state_nxt    = REQ_C;
                end
            end
            REQ_C: begin
                if (mem_ack) begin
                    bundle_nxt.c = mem_rdata;
                    pc_nxt       = pc_inc;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) state_nxt = WAIT_EXEC;
            end
            WAIT_EXEC: begin
                if (exec_done) begin
                    if (!branch_taken) begin
                        state_nxt = REQ_A;
                    end else if (!bundle.c[WIDTH-1]) begin
                        pc_nxt    = bundle.c;
                        state_nxt = REQ_A;
                    end else begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase

`ifdef SUBNEG_PC_WRAP_CHECK_EN
        // A sequential step off the top of the address space is fatal; branch loads never wrap.
        if (wrap_fire) state_nxt = HALT;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            bundle <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            bundle <= bundle_nxt;
        end
    end

`ifdef SUBNEG_PC_WRAP_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_ovf <= 1'b0;
        end else if (wrap_fire) begin
            pc_ovf <= 1'b1;
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap_fire;
`endif

endmodule

// File: tb/tb_subneg_fetch.sv
// Directed self-checking bench for subneg_fetch (WIDTH=8, RESET_PC=0).
module tb_subneg_fetch;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] op_a, op_b, op_c, instr_pc;
    logic       exec_done;
    logic       branch_taken;
    logic       halted;
    logic [7:0] pc;
`ifdef SUBNEG_PC_WRAP_CHECK_EN
    logic       pc_ovf;
`endif

    logic [7:0] mem [256];
    logic       ack_hold;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clock = ~clock;

    assign mem_ack   = mem_req & ~ack_hold;
    assign mem_rdata = mem[mem_addr];

    subneg_fetch #(.WIDTH(8), .RESET_PC(8'h00)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_c         (op_c),
        .instr_pc     (instr_pc),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .halted       (halted),
`ifdef SUBNEG_PC_WRAP_CHECK_EN
        .pc_ovf       (pc_ovf),
`endif
        .pc           (pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        start        = 1'b0;
        instr_ready  = 1'b0;
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        ack_hold     = 1'b0;
        #12;
        reset_n = 1'b1;
    endtask

    // Entered in REQ_A with zero-wait memory; leaves in the next REQ_A.
    task automatic run_fall();
        repeat (3) step();
        instr_ready = 1'b1;
        step();
        instr_ready  = 1'b0;
        exec_done    = 1'b1;
        branch_taken = 1'b0;
        step();
        exec_done = 1'b0;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[8'h00] = 8'h05; mem[8'h01] = 8'h06; mem[8'h02] = 8'h03;
        mem[8'h03] = 8'h01; mem[8'h04] = 8'h02; mem[8'h05] = 8'h10;
        mem[8'h10] = 8'h00; mem[8'h11] = 8'h00; mem[8'h12] = 8'hFF;

        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_req", mem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_op_a", op_a, 8'h00);

        // First instruction with zero-wait memory
        step();
        check("idle_no_req", mem_req, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("a_req", mem_req, 1'b1);
        check("a_addr", mem_addr, 8'h00);
        step();
        check("b_addr", mem_addr, 8'h01);
        step();
        check("c_addr", mem_addr, 8'h02);
        step();
        check("iss_valid", instr_valid, 1'b1);
        check("iss_req", mem_req, 1'b0);
        check("iss_op_a", op_a, 8'h05);
        check("iss_op_b", op_b, 8'h06);
        check("iss_op_c", op_c, 8'h03);
        check("iss_ipc", instr_pc, 8'h00);
        check("iss_pc", pc, 8'h03);

        // Backpressure: bundle stays put while instr_ready is low
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_valid", instr_valid, 1'b1);
            check("bp_op_b", op_b, 8'h06);
            check("bp_op_c", op_c, 8'h03);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("hs_valid_drop", instr_valid, 1'b0);

        // Fall-through
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("ft_addr", mem_addr, 8'h03);
        check("ft_req", mem_req, 1'b1);

        // Word B acknowledged three cycles late
        step();
        ack_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ws_req", mem_req, 1'b1);
            check("ws_addr", mem_addr, 8'h04);
            check("ws_pc", pc, 8'h04);
            step();
        end
        ack_hold = 1'b0;
        check("ws_addr_hold", mem_addr, 8'h04);
        step();
        check("ws_c_addr", mem_addr, 8'h05);
        step();
        check("i2_valid", instr_valid, 1'b1);
        check("i2_ipc", instr_pc, 8'h03);
        check("i2_op_c", op_c, 8'h10);
        check("i2_pc", pc, 8'h06);

        // Handshake with exec_done already asserted: next REQ_A two cycles later
        instr_ready  = 1'b1;
        exec_done    = 1'b1;
        branch_taken = 1'b1;
        step();
        instr_ready = 1'b0;
        check("br_wait_req", mem_req, 1'b0);
        check("br_wait_valid", instr_valid, 1'b0);
        step();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        check("br_req", mem_req, 1'b1);
        check("br_addr", mem_addr, 8'h10);

        // Branch to a negative target halts
        repeat (3) step();
        check("h_op_c", op_c, 8'hFF);
        instr_ready = 1'b1;
        step();
        instr_ready  = 1'b0;
        exec_done    = 1'b1;
        branch_taken = 1'b1;
        step();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        check("h_halted", halted, 1'b1);
        check("h_req", mem_req, 1'b0);
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        check("h_sticky", halted, 1'b1);
        check("h_req_start", mem_req, 1'b0);
        check("h_pc", pc, 8'h13);

        // Asynchronous reset in the middle of REQ_B
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        ack_hold = 1'b1;
        check("mr_in_b", mem_addr, 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_req_async", mem_req, 1'b0);
        check("mr_pc", pc, 8'h00);
        check("mr_halted", halted, 1'b0);
        #3;
        reset_n  = 1'b1;
        ack_hold = 1'b0;
        step();
        check("mr_idle", mem_req, 1'b0);

        // Walk the PC up to 0xFF with fall-through instructions, then step across the wrap
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 85; i++) run_fall();
        check("wr_addr_ff", mem_addr, 8'hFF);
        check("wr_req_ff", mem_req, 1'b1);
        step();
        check("wr_pc", pc, 8'h00);
`ifdef SUBNEG_PC_WRAP_CHECK_EN
        check("wr_halted", halted, 1'b1);
        check("wr_ovf", pc_ovf, 1'b1);
        check("wr_req", mem_req, 1'b0);
`else
        check("wr_halted", halted, 1'b0);
        check("wr_req", mem_req, 1'b1);
        check("wr_addr", mem_addr, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
